// File: rtl/frame_swap_pkg.sv
// frame_swap_pkg
//   Shared definitions for the frame-buffer ownership controller:
//   swap-mode encodings, the largest supported buffer count and a helper
//   that picks a free buffer index.
package frame_swap_pkg;

  // Swap mode encodings as presented on the mode input.
  localparam logic [1:0] MODE_IMMEDIATE = 2'd0;
  localparam logic [1:0] MODE_VSYNC     = 2'd1;
  localparam logic [1:0] MODE_MAILBOX   = 2'd2;
  localparam logic [1:0] MODE_RESERVED  = 2'd3;

  // Largest buffer count the controller is built for.
  localparam int MAX_BUFS = 4;

  // Lowest buffer index below num_bufs that is neither a nor b.
  // Scanning downwards lets the last hit (the lowest index) win.
  function automatic int free_idx(input int num_bufs, input int a, input int b);
    free_idx = 0;
    for (int i = MAX_BUFS - 1; i >= 0; i--) begin
      if (i < num_bufs && i != a && i != b) begin
        free_idx = i;
      end
    end
  endfunction

endpackage

// File: rtl/vsync_edge_sync.sv
// vsync_edge_sync
//   Brings the asynchronous vsync pulse into the CLK domain and produces a
//   one-cycle strobe on the trailing edge of the active pulse.
//   Ports:
//     CLK      in  system clock
//     rst      in  synchronous active-high reset
//     vsync    in  asynchronous vsync from the timing generator
//     vs_event out one-cycle strobe, trailing edge of the active pulse
module vsync_edge_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter bit VS_ACTIVE_LOW = 1'b1
) (
  input  logic CLK,
  input  logic rst,
  input  logic vsync,
  output logic vs_event
);

  // Polarity is normalised in front of the first flop so the chain always
  // carries "pulse active"; a cleared chain then reads as "no pulse" and
  // leaving reset can never fake a trailing edge.
  logic vs_active;
  assign vs_active = VS_ACTIVE_LOW ? ~vsync : vsync;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   last_reg;

  always_ff @(posedge CLK) begin
    if (rst) begin
      sync_reg <= '0;
      last_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], vs_active};
      last_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  // Active in the previous cycle, inactive now: the pulse just ended.
  assign vs_event = last_reg & ~sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/frame_swap_ctrl.sv
// frame_swap_ctrl
//   Frame-buffer ownership controller. Tracks the buffer scanned out
//   (front), the buffer being rendered (back) and, in mailbox mode, one
//   completed frame waiting for display (ready). Swaps happen immediately
//   or on the vsync trailing edge.
//   Ports:
//     CLK        in  system clock
//     rst        in  synchronous active-high reset
//     vsync      in  asynchronous vsync
//     mode       in  0 immediate, 1 vsync, 2 mailbox, 3 treated as vsync
//     swap_req   in  renderer finished the back buffer (strobe)
//     back_valid out renderer may write back_idx
//     back_idx   out buffer owned by the renderer
//     front_idx  out buffer owned by scanout
//     swap_ack   out pulse on the edge front_idx changes
//     pending    out completed frame waiting for vsync
//     frame_cnt  out vsync event count, wraps
//     drop_cnt   out mailbox frames overwritten unseen, saturates
module frame_swap_ctrl
  import frame_swap_pkg::*;
#(
  parameter int NUM_BUFS      = 3,
  parameter bit VS_ACTIVE_LOW = 1'b1,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 16,
  // Derived from NUM_BUFS; not meant to be overridden.
  parameter int IDX_W         = (NUM_BUFS > 2) ? $clog2(NUM_BUFS) : 1
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             vsync,
  input  logic [1:0]       mode,
  input  logic             swap_req,
  output logic             back_valid,
  output logic [IDX_W-1:0] back_idx,
  output logic [IDX_W-1:0] front_idx,
  output logic             swap_ack,
  output logic             pending,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  logic vs_event;

  vsync_edge_sync #(
    .SYNC_STAGES  (SYNC_STAGES),
    .VS_ACTIVE_LOW(VS_ACTIVE_LOW)
  ) u_vsync_edge_sync (
    .CLK     (CLK),
    .rst     (rst),
    .vsync   (vsync),
    .vs_event(vs_event)
  );

  // pending_reg means "a completed frame is queued": in vsync mode it is
  // the back buffer handed over, in mailbox mode it is ready_reg valid.
  // Mode only changes while nothing is queued, so one flag serves both.
  logic [IDX_W-1:0] front_reg,     front_next;
  logic [IDX_W-1:0] back_reg,      back_next;
  logic [IDX_W-1:0] ready_reg,     ready_next;
  logic             back_valid_reg, back_valid_next;
  logic             pending_reg,   pending_next;
  logic             swap_ack_reg,  swap_ack_next;
  logic [CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic [CNT_W-1:0] drop_cnt_reg,  drop_cnt_next;
  logic [1:0]       mode_q_reg,    mode_q_next;

  logic [1:0]       eff_mode;
  logic             idle;
  logic             accept;
  logic [IDX_W-1:0] spare_idx;

  // Reserved encoding, and mailbox without a third buffer, fall back to
  // plain vsync-aligned double buffering.
  always_comb begin
    eff_mode = mode_q_reg;
    if (mode_q_reg == MODE_RESERVED) begin
      eff_mode = MODE_VSYNC;
    end
    if (mode_q_reg == MODE_MAILBOX && NUM_BUFS < 3) begin
      eff_mode = MODE_VSYNC;
    end
  end

  assign idle      = back_valid_reg & ~pending_reg;
  assign accept    = swap_req & back_valid_reg;
  assign spare_idx = IDX_W'(free_idx(NUM_BUFS, int'(front_reg), int'(back_reg)));

  always_comb begin
    front_next      = front_reg;
    back_next       = back_reg;
    ready_next      = ready_reg;
    back_valid_next = back_valid_reg;
    pending_next    = pending_reg;
    swap_ack_next   = 1'b0;
    frame_cnt_next  = frame_cnt_reg;
    drop_cnt_next   = drop_cnt_reg;
    mode_q_next     = idle ? mode : mode_q_reg;

    if (vs_event) begin
      frame_cnt_next = frame_cnt_reg + CNT_W'(1);
    end

    case (eff_mode)
      MODE_IMMEDIATE: begin
        if (accept) begin
          front_next    = back_reg;
          back_next     = front_reg;
          swap_ack_next = 1'b1;
        end
      end

      MODE_MAILBOX: begin
        if (accept) begin
          ready_next   = back_reg;
          pending_next = 1'b1;
          if (pending_reg && vs_event) begin
            // Queued frame goes on screen while the new one takes its
            // place; the retired front becomes the render target.
            front_next    = ready_reg;
            back_next     = front_reg;
            swap_ack_next = 1'b1;
          end else if (pending_reg) begin
            // Queued frame never reached the screen: recycle it.
            back_next = ready_reg;
            if (drop_cnt_reg != '1) begin
              drop_cnt_next = drop_cnt_reg + CNT_W'(1);
            end
          end else begin
            back_next = spare_idx;
          end
        end else if (vs_event && pending_reg) begin
          // Old front is simply released; it becomes the spare buffer.
          front_next    = ready_reg;
          pending_next  = 1'b0;
          swap_ack_next = 1'b1;
        end
      end

      default: begin
        // A request in the same cycle as vs_event only arms the swap; it
        // completes at the following vs_event.
        if (pending_reg && vs_event) begin
          front_next      = back_reg;
          back_next       = front_reg;
          pending_next    = 1'b0;
          back_valid_next = 1'b1;
          swap_ack_next   = 1'b1;
        end else if (accept) begin
          pending_next    = 1'b1;
          back_valid_next = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      front_reg      <= IDX_W'(0);
      back_reg       <= IDX_W'(1);
      ready_reg      <= '0;
      back_valid_reg <= 1'b1;
      pending_reg    <= 1'b0;
      swap_ack_reg   <= 1'b0;
      frame_cnt_reg  <= '0;
      drop_cnt_reg   <= '0;
      mode_q_reg     <= MODE_VSYNC;
    end else begin
      front_reg      <= front_next;
      back_reg       <= back_next;
      ready_reg      <= ready_next;
      back_valid_reg <= back_valid_next;
      pending_reg    <= pending_next;
      swap_ack_reg   <= swap_ack_next;
      frame_cnt_reg  <= frame_cnt_next;
      drop_cnt_reg   <= drop_cnt_next;
      mode_q_reg     <= mode_q_next;
    end
  end

  assign back_valid = back_valid_reg;
  assign back_idx   = back_reg;
  assign front_idx  = front_reg;
  assign swap_ack   = swap_ack_reg;
  assign pending    = pending_reg;
  assign frame_cnt  = frame_cnt_reg;
  assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// tb_frame_swap_ctrl
//   Drives a triple-buffer (dut0) and a double-buffer (dut1) controller
//   with the same stimulus and checks both against a behavioural model
//   every cycle, plus literal expectations at key points.
module tb_frame_swap_ctrl;

  localparam int S = 2;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b1;
  logic [1:0] mode = 2'd1;
  logic       swap_req = 1'b0;

  logic        bv0, ack0, pend0;
  logic [1:0]  back0, front0;
  logic [15:0] fc0, dc0;
  logic        bv1, ack1, pend1;
  logic [0:0]  back1, front1;
  logic [15:0] fc1, dc1;

  frame_swap_ctrl #(.NUM_BUFS(3), .VS_ACTIVE_LOW(1'b1), .SYNC_STAGES(S), .CNT_W(16)) dut0 (
    .CLK(CLK), .rst(rst), .vsync(vsync), .mode(mode), .swap_req(swap_req),
    .back_valid(bv0), .back_idx(back0), .front_idx(front0), .swap_ack(ack0),
    .pending(pend0), .frame_cnt(fc0), .drop_cnt(dc0));

  frame_swap_ctrl #(.NUM_BUFS(2), .VS_ACTIVE_LOW(1'b1), .SYNC_STAGES(S), .CNT_W(16)) dut1 (
    .CLK(CLK), .rst(rst), .vsync(vsync), .mode(mode), .swap_req(swap_req),
    .back_valid(bv1), .back_idx(back1), .front_idx(front1), .swap_ack(ack1),
    .pending(pend1), .frame_cnt(fc1), .drop_cnt(dc1));

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int nb[2] = '{3, 2};
  int m_front[2], m_back[2], m_ready[2], m_fc[2], m_dc[2], m_mode[2];
  bit m_bv[2], m_pend[2], m_rv[2], m_ack[2];

  bit hist[0:16383];
  int edge_n = 0;

  function automatic int lowest_free(input int n, input int a, input int b);
    for (int i = 0; i < n; i++) if (i != a && i != b) return i;
    return 0;
  endfunction

  task automatic model_step(input int j, input bit ev);
    bit acc, idle;
    int eff, t;
    if (rst) begin
      m_front[j] = 0; m_back[j] = 1; m_ready[j] = 0;
      m_bv[j] = 1; m_pend[j] = 0; m_rv[j] = 0; m_ack[j] = 0;
      m_fc[j] = 0; m_dc[j] = 0; m_mode[j] = 1;
      return;
    end
    acc  = swap_req && m_bv[j];
    idle = m_bv[j] && !m_pend[j] && !m_rv[j];
    eff  = m_mode[j];
    if (eff == 3) eff = 1;
    if (eff == 2 && nb[j] == 2) eff = 1;
    m_ack[j] = 0;
    if (ev) m_fc[j] = (m_fc[j] + 1) % 65536;
    if (eff == 0) begin
      if (acc) begin
        t = m_front[j]; m_front[j] = m_back[j]; m_back[j] = t; m_ack[j] = 1;
      end
    end else if (eff == 2) begin
      if (acc && ev && m_rv[j]) begin
        t = m_ready[j]; m_ready[j] = m_back[j]; m_back[j] = m_front[j];
        m_front[j] = t; m_ack[j] = 1;
      end else if (acc && m_rv[j]) begin
        t = m_ready[j]; m_ready[j] = m_back[j]; m_back[j] = t;
        if (m_dc[j] < 65535) m_dc[j]++;
      end else if (acc) begin
        t = lowest_free(nb[j], m_front[j], m_back[j]);
        m_ready[j] = m_back[j]; m_back[j] = t; m_rv[j] = 1;
      end else if (ev && m_rv[j]) begin
        m_front[j] = m_ready[j]; m_rv[j] = 0; m_ack[j] = 1;
      end
    end else begin
      if (m_pend[j] && ev) begin
        t = m_front[j]; m_front[j] = m_back[j]; m_back[j] = t;
        m_pend[j] = 0; m_bv[j] = 1; m_ack[j] = 1;
      end else if (acc) begin
        m_pend[j] = 1; m_bv[j] = 0;
      end
    end
    if (idle) m_mode[j] = mode;
  endtask

  task automatic compare_dut(input int j, input int f, input int b, input int bv,
                             input int ack, input int pend, input int fc, input int dc);
    chk($sformatf("d%0d_front", j), f, m_front[j]);
    chk($sformatf("d%0d_back", j), b, m_back[j]);
    chk($sformatf("d%0d_back_valid", j), bv, int'(m_bv[j]));
    chk($sformatf("d%0d_swap_ack", j), ack, int'(m_ack[j]));
    chk($sformatf("d%0d_pending", j), pend, int'(m_pend[j] || m_rv[j]));
    chk($sformatf("d%0d_frame_cnt", j), fc, m_fc[j]);
    chk($sformatf("d%0d_drop_cnt", j), dc, m_dc[j]);
    // Front and back must always be different buffers.
    chk($sformatf("d%0d_front_ne_back", j), int'(f != b), 1);
  endtask

  // Deassertion sampled at edge k takes effect at edge k+S.
  always @(posedge CLK) begin
    bit ev;
    ev = (edge_n >= S + 1) && hist[edge_n-S-1] && !hist[edge_n-S];
    hist[edge_n] = rst ? 1'b0 : !vsync;
    if (rst) begin
      for (int i = edge_n - S - 1; i <= edge_n; i++) if (i >= 0) hist[i] = 1'b0;
    end
    model_step(0, ev);
    model_step(1, ev);
    edge_n++;
    #1;
    compare_dut(0, int'(front0), int'(back0), int'(bv0), int'(ack0), int'(pend0), int'(fc0), int'(dc0));
    compare_dut(1, int'(front1), int'(back1), int'(bv1), int'(ack1), int'(pend1), int'(fc1), int'(dc1));
    // The model's ready buffer must also be distinct from front and back.
    if (m_rv[0]) chk("model_ready_distinct",
                     int'(m_ready[0] != m_front[0] && m_ready[0] != m_back[0]), 1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_swap();
    swap_req = 1'b1;
    @(negedge CLK);
    swap_req = 1'b0;
  endtask

  // Low pulse, then wait until the resulting vs_event has been acted on.
  task automatic vs_pulse(input int low_cycles);
    vsync = 1'b0;
    repeat (low_cycles) @(negedge CLK);
    vsync = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  // Trailing edge with a swap_req landing in the vs_event cycle.
  task automatic vs_with_swap();
    vsync = 1'b0;
    repeat (3) @(negedge CLK);
    vsync = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    swap_req = 1'b1;
    @(negedge CLK);
    swap_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    rst = 1'b0;
    chk("rst_front", front0, 0);
    chk("rst_back", back0, 1);
    chk("rst_back_valid", bv0, 1);
    chk("rst_pending", pend0, 0);
    chk("rst_counters", int'(fc0) + int'(dc0), 0);
    @(negedge CLK);

    // VSYNC mode, swap then a 10-cycle vsync pulse
    pulse_swap();
    chk("vs_pending", pend0, 1);
    chk("vs_back_valid_low", bv0, 0);
    chk("vs2_pending", pend1, 1);
    pulse_swap();
    chk("vs_second_req_front", front0, 0);
    chk("vs_second_req_pending", pend0, 1);
    vsync = 1'b0;
    repeat (10) @(negedge CLK);
    vsync = 1'b1;
    @(negedge CLK);
    chk("vs_ack_k", ack0, 0);
    @(negedge CLK);
    chk("vs_ack_k1", ack0, 0);
    chk("vs_front_k1", front0, 0);
    @(negedge CLK);
    chk("vs_ack_k2", ack0, 1);
    chk("vs_front", front0, 1);
    chk("vs_back", back0, 0);
    chk("vs2_front", front1, 1);
    chk("vs2_back", back1, 0);
    chk("vs_back_valid_back", bv0, 1);
    chk("vs_frame_cnt", fc0, 1);
    @(negedge CLK);
    chk("vs_ack_one_cycle", ack0, 0);

    // Same-cycle swap_req and vs_event: armed only
    vs_with_swap();
    chk("same_pending", pend0, 1);
    chk("same_front", front0, 1);
    chk("same_ack", ack0, 0);
    chk("same_frame_cnt", fc0, 2);
    vs_pulse(3);
    chk("same_next_front", front0, 0);
    chk("same_next_back", back0, 1);
    chk("same_next_ack", ack0, 1);
    chk("same_next_fc", fc0, 3);

    // Mode written while pending: old mode until the swap completes
    pulse_swap();
    mode = 2'd2;
    chk("mch_back_valid", bv0, 0);
    @(negedge CLK);
    pulse_swap();
    chk("mch_still_vsync", bv0, 0);
    vs_pulse(3);
    chk("mch_front", front0, 1);
    chk("mch_fc", fc0, 4);
    @(negedge CLK);
    pulse_swap();
    chk("mch_mailbox_bv", bv0, 1);
    chk("mch_mailbox_back", back0, 2);
    chk("mch_mailbox_pending", pend0, 1);
    chk("mch_2buf_vsync_bv", bv1, 0);

    // Reset with a ready frame queued
    do_reset();
    chk("rst2_front", front0, 0);
    chk("rst2_back", back0, 1);
    chk("rst2_pending", pend0, 0);
    chk("rst2_fc", fc0, 0);
    @(negedge CLK);

    // MAILBOX: three frames, no vsync
    pulse_swap();
    chk("mb1_back", back0, 2);
    chk("mb1_drop", dc0, 0);
    pulse_swap();
    chk("mb2_back", back0, 1);
    chk("mb2_drop", dc0, 1);
    pulse_swap();
    chk("mb3_back", back0, 2);
    chk("mb3_drop", dc0, 2);
    chk("mb3_front", front0, 0);
    chk("mb3_bv", bv0, 1);
    chk("model_pin_drop", m_dc[0], 2);
    chk("model_pin_ready", m_ready[0], 1);
    vs_pulse(3);
    chk("mb_vs_front", front0, 1);
    chk("mb_vs_ack", ack0, 1);
    chk("mb_vs_pending", pend0, 0);
    chk("mb_vs_back", back0, 2);

    // MAILBOX: same cycle, ready valid
    pulse_swap();
    chk("mbs_back", back0, 0);
    vs_with_swap();
    chk("mbs_front", front0, 2);
    chk("mbs_back2", back0, 1);
    chk("mbs_drop", dc0, 2);
    chk("mbs_ack", ack0, 1);
    chk("mbs_pending", pend0, 1);
    vs_pulse(3);
    chk("mbs_next_front", front0, 0);
    chk("mbs_next_pending", pend0, 0);

    // MAILBOX: same cycle, ready invalid
    vs_with_swap();
    chk("mbi_front", front0, 0);
    chk("mbi_back", back0, 2);
    chk("mbi_pending", pend0, 1);
    chk("mbi_ack", ack0, 0);
    vs_pulse(3);
    chk("mbi_next_front", front0, 1);
    chk("mbi_next_ack", ack0, 1);

    // IMMEDIATE
    mode = 2'd0;
    do_reset();
    @(negedge CLK);
    pulse_swap();
    chk("imm_front", front0, 1);
    chk("imm_back", back0, 0);
    chk("imm_ack", ack0, 1);
    chk("imm2_front", front1, 1);
    @(negedge CLK);
    chk("imm_ack_clear", ack0, 0);
    vs_pulse(3);
    chk("imm_vs_front", front0, 1);
    chk("imm_vs_fc", fc0, 1);
    chk("imm_vs_ack", ack0, 0);

    // Random run; per-cycle model compare includes distinctness
    for (int c = 0; c < 600; c++) begin
      swap_req = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) vsync = ~vsync;
      if ($urandom_range(0, 40) == 0) mode = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 199) == 0);
      @(negedge CLK);
    end
    swap_req = 1'b0;
    rst = 1'b0;
    vsync = 1'b1;
    repeat (5) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
